// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  function automatic int unsigned clocks_per_bit(int unsigned clock_frequency,
                                                 int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  // XOR of up to 9 data bits; narrower words are zero-extended by the caller.
  function automatic logic parity_of(logic [8:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and combinational read data at the head.
module uart_sync_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_q, rd_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign rdata_o = mem_q[rd_q[PtrW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[PtrW-1:0]] <= wdata_i;
        wr_q                  <= wr_q + (PtrW+1)'(1);
      end
      if (pop_ok) rd_q <= rd_q + (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling and a receive FIFO on a valid/ready port.
// Optional parity bit and check compiled in with UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 12_000_000,
  parameter int unsigned BaudRate       = 9_600,
  parameter int unsigned DataBits       = 8,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned ParityOdd      = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                err_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam int unsigned ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);
  localparam int unsigned CntW         = $clog2(ClocksPerBit);
  localparam int unsigned IdxW         = $clog2(DataBits);
  localparam logic [CntW-1:0] HalfLoad = CntW'(ClocksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(ClocksPerBit - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DataBits - 1);

  uart_rx_state_e      state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                wait_high_q, wait_high_d;
  logic                rx_meta_q, rx_s;
  logic                push, fifo_full, fifo_empty;
  logic                par_err_q;
  logic [DataBits:0]   push_word;

`ifdef UART_RX_PARITY_EN
  logic par_err_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = 1'(ParityOdd);
  assign par_err_q         = 1'b0;
`endif

  // Two-flop synchronizer, idle-high at reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      wait_high_q <= wait_high_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state and datapath; every sample happens when the bit counter expires.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    wait_high_d = wait_high_q;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (state_q != IDLE && cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    case (state_q)
      IDLE: begin
        if (wait_high_q) begin
          if (rx_s) wait_high_d = 1'b0;
        end else if (!rx_s) begin
          cnt_d   = HalfLoad;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FullLoad;
            idx_d   = '0;
            state_d = DATA;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          data_d[idx_q] = rx_s;
          cnt_d         = FullLoad;
          if (idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          par_err_d = (parity_of(9'(data_q)) ^ rx_s) != 1'(ParityOdd);
          cnt_d     = FullLoad;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          push        = 1'b1;
          wait_high_d = !rx_s;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_word = {!rx_s | par_err_q, data_q};

  uart_sync_fifo #(
    .Width (DataBits + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (ready_i),
    .rdata_o ({err_o, data_o}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o = !fifo_empty;
  assign busy_o  = (state_q != IDLE);

  // Drop pulse: a full FIFO can only take the frame if the head pops this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overrun_o <= 1'b0;
    else         overrun_o <= push && fifo_full && !ready_i;
  end

endmodule
